fsm_shift_feeder: RTL and testbench
===================================

# fsm_shift_feeder

Upstream driver for the nibble shift FSM. It accepts 4-bit words from a producer over a valid/ready handshake and buffers them in a small FIFO. It then replays each word to the shifter's `load`/`data` inputs using the pulse protocol the shifter needs: `load` high, then low for at least two cycles with `data` held stable. This lets producers stream nibbles at full rate without knowing the shifter's state sequence.

## Interface
- `DEPTH`, 4: FIFO entries; power of 2, ≥2.
- `HOLD`, 1: cycles `load` stays high per word; ≥1.
- `GAP`, 2: cycles `load` stays low after each pulse; ≥2, because the shifter needs one cycle in its capture state and one in its shift state before it returns to idle.
- `CW`, $clog2(DEPTH)+1: width of `count`; derived, not overridable.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  producer has a word.
- `in_ready`  out  1  FIFO can accept a word; equals `!full`, combinational.
- `in_data`  in  4  word from the producer.
- `load`  out  1  to the shifter's `load`; registered.
- `data`  out  4  to the shifter's `data`; registered, stable for the whole pulse plus gap.
- `busy`  out  1  high in LOAD or GAP.
- `count`  out  CW  FIFO occupancy, 0..DEPTH.

## Operation
- Push: when `in_valid && in_ready` at a rising edge, write `in_data` to the tail.
- When full, `in_ready`=0 even if a pop happens in the same cycle. There is no pass-through path.
- FSM states:
  - IDLE: `load`=0. If `count`≠0 at the edge: pop the head into `data`, set `load`=1, clear the counter, go to LOAD.
  - LOAD: `load`=1 for HOLD cycles. On the last one: `load`=0, clear the counter, go to GAP.
  - GAP: `load`=0, `data` held. On the last GAP cycle:
    - if `count`≠0, pop, `load`=1, go to LOAD (back-to-back);
    - otherwise go to IDLE.
- Pop happens only in the two transitions above. FIFO order is strict.
- Push and pop in the same cycle: `count` is unchanged, and both pointers advance modulo DEPTH.
- Pointers wrap naturally. Full/empty are resolved by `count`, not by pointer compare.
- `data` changes only on a pop. In IDLE it keeps the last word.
- Illegal parameters (GAP<2, HOLD<1, DEPTH not a power of 2 or <2) are an elaboration-time error.

## Timing
- Reset values (async, immediate on `rst_n`=0):
  - `load`=0, `data`=0, `busy`=0, `count`=0;
  - `in_ready`=1 after reset (empty FIFO); FSM=IDLE; pointers=0.
- FIFO contents are not reset.
- Latency: a word accepted at edge k with an empty FIFO and the FSM in IDLE drives `load`=1 and `data`=word from edge k+1.
- `load` is high for exactly HOLD cycles, then low for at least GAP cycles.
- Sustained throughput: one word per HOLD+GAP cycles. Defaults give 3 cycles per word.
- Reset mid-pulse drops `load` asynchronously and discards all buffered words. The shifter is reset on its own reset.
- `busy` is registered and matches the FSM state (LOAD or GAP).

## Structure
- A shared package `shift_pkg` holds:
  - `NIB_W`=4;
  - the state encoding: IDLE=2'b00, LOAD=2'b01, GAP=2'b10;
  - parameter legality checks.
- The natural sub-module is `nibble_fifo`: parameterised DEPTH, with push/pop/full/empty/count ports. The top level holds the FSM and the HOLD/GAP counter, whose width is $clog2(max(HOLD,GAP))+1.

## Test plan
- Single word: push 4'hA at edge k (defaults) -> `load`=1 during cycle k+1 only, `data`=4'hA cycles k+1..k+3. The attached shifter outputs 4'hA, then 4'h5.
- Burst 1,2,3,4 on consecutive cycles -> four `load` pulses exactly 3 cycles apart. `data` sequence is 1,2,3,4. `busy` stays high throughout and falls 3 cycles after the 4th pulse starts.
- Overflow: DEPTH=4, HOLD=4, push 6 words back-to-back -> `in_ready` goes low when `count`=4. The extra words are held off, none is lost, and output order is preserved.
- Push and pop in the same cycle at `count`=2 -> `count` stays 2 and pointers wrap past DEPTH-1 correctly.
- Reset asserted during LOAD with 3 words queued -> `load`=0 immediately, `count`=0, `in_ready`=1. After release, no pulse occurs until the next push.
- Idle: no `in_valid` for 20 cycles -> `load`=0, `data` holds the last word, `busy`=0.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the nibble shifter feeder: word width, FSM state
// encoding and the parameter legality rule used at elaboration.
package shift_pkg;

    localparam int NIB_W = 4;

    // FSM state encoding shared with the shifter-side tooling
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_LOAD = 2'b01;
    localparam logic [1:0] ST_GAP  = 2'b10;

    // Larger of two integers, used to size the HOLD/GAP counter
    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The FIFO needs a power-of-two depth so its pointers wrap by overflow;
    // the shifter needs at least one high cycle and two low cycles per word
    function automatic bit paramsLegal(input int depth, input int hold, input int gap);
        return (depth >= 2) && ((depth & (depth - 1)) == 0) && (hold >= 1) && (gap >= 2);
    endfunction

endpackage

// File: rtl/nibble_fifo.sv
// Small power-of-two FIFO of nibbles. Occupancy is tracked by an explicit
// counter so full/empty never depend on pointer comparison. Storage is not
// reset; only pointers and the counter are.
module nibble_fifo
    import shift_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [NIB_W-1:0] wdata_i,
    input  logic             pop_i,
    output logic [NIB_W-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [NIB_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [CW-1:0]    count_q, count_d;

    // Pointer and occupancy next-state; simultaneous push and pop leave the count alone
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (push_i) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end
        if (pop_i) begin
            rdPtr_d = rdPtr_q + AW'(1);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage write; contents survive reset since the counter marks them invalid
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rdPtr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/fsm_shift_feeder.sv
// Feeder for the nibble shift FSM: buffers producer nibbles and replays each
// one as a load pulse of HOLD cycles followed by at least GAP low cycles,
// keeping data stable across the whole pulse and gap.
module fsm_shift_feeder
    import shift_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int HOLD  = 1,
    parameter  int GAP   = 2,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NIB_W-1:0] in_data,
    output logic             load,
    output logic [NIB_W-1:0] data,
    output logic             busy,
    output logic [CW-1:0]    count
);

    // One counter times both the high and the low phase of a pulse
    localparam int TW = $clog2(maxInt(HOLD, GAP)) + 1;

    generate
        if (!paramsLegal(DEPTH, HOLD, GAP)) begin : gParamCheck
            $error("fsm_shift_feeder: DEPTH must be a power of 2 >= 2, HOLD >= 1, GAP >= 2");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic             load_q, load_d;
    logic [NIB_W-1:0] data_q, data_d;
    logic             busy_q, busy_d;

    logic             fifoPush;
    logic             fifoPop;
    logic [NIB_W-1:0] fifoHead;
    logic             fifoFull;
    logic             fifoEmpty;
    logic [CW-1:0]    fifoCount;

    // A full FIFO refuses words even when a pop happens in the same cycle
    assign in_ready = !fifoFull;
    assign fifoPush = in_valid && in_ready;

    nibble_fifo #(
        .DEPTH(DEPTH)
    ) uFifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (fifoPush),
        .wdata_i(in_data),
        .pop_i  (fifoPop),
        .rdata_o(fifoHead),
        .full_o (fifoFull),
        .empty_o(fifoEmpty),
        .count_o(fifoCount)
    );

    // Pulse sequencer: pops only when starting a pulse, from IDLE or at the end of a gap
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        load_d  = load_q;
        data_d  = data_q;
        fifoPop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                load_d = 1'b0;
                if (!fifoEmpty) begin
                    fifoPop = 1'b1;
                    data_d  = fifoHead;
                    load_d  = 1'b1;
                    tick_d  = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (tick_q == TW'(HOLD - 1)) begin
                    load_d  = 1'b0;
                    tick_d  = '0;
                    state_d = ST_GAP;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            ST_GAP: begin
                if (tick_q == TW'(GAP - 1)) begin
                    tick_d = '0;
                    if (!fifoEmpty) begin
                        fifoPop = 1'b1;
                        data_d  = fifoHead;
                        load_d  = 1'b1;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            default: begin
                load_d  = 1'b0;
                tick_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Sequencer registers; reset drops load at once and returns to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            load_q  <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            load_q  <= load_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    assign load  = load_q;
    assign data  = data_q;
    assign busy  = busy_q;
    assign count = fifoCount;

endmodule

// File: tb/tb_fsm_shift_feeder.sv
// Bench for fsm_shift_feeder: two instances (default timing and a slow
// HOLD=4/GAP=3 variant) share one producer and are compared every cycle
// against a queue-and-timestamp model of the pulse schedule.
module tb_fsm_shift_feeder;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic inValid;
    logic [3:0] inData;

    logic ready0, load0, busy0;
    logic [3:0] data0;
    logic [CW-1:0] count0;
    logic ready1, load1, busy1;
    logic [3:0] data1;
    logic [CW-1:0] count1;

    int testsRun = 0;
    int testsFailed = 0;
    int cycle = 0;

    // Model: per instance, the queued words, the cycle the latest pulse began
    // and the word it carried. A pulse may begin once HOLD+GAP cycles have
    // elapsed since the previous one and a word was queued before that edge.
    logic [3:0] modelQ [2][$];
    int lastStart [2];
    logic [3:0] lastData [2];
    int holdOf [2] = '{1, 4};
    int gapOf  [2] = '{2, 3};

    always #5 clk = ~clk;

    fsm_shift_feeder #(.DEPTH(DEPTH), .HOLD(1), .GAP(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(ready0),
        .in_data(inData), .load(load0), .data(data0), .busy(busy0), .count(count0)
    );

    fsm_shift_feeder #(.DEPTH(DEPTH), .HOLD(4), .GAP(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(ready1),
        .in_data(inData), .load(load1), .data(data1), .busy(busy1), .count(count1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s at cycle %0d: observed %0h expected %0h", tag, cycle, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            modelQ[i].delete();
            lastStart[i] = -1000;
            lastData[i] = 4'h0;
        end
    endtask

    task automatic modelEdge(input int i);
        int preSize;
        preSize = modelQ[i].size();
        if (preSize > 0 && cycle >= lastStart[i] + holdOf[i] + gapOf[i]) begin
            lastData[i] = modelQ[i].pop_front();
            lastStart[i] = cycle;
        end
        if (inValid && preSize < DEPTH) begin
            modelQ[i].push_back(inData);
        end
    endtask

    task automatic compareInstance(input int i, input logic obsLoad, input logic obsBusy,
                                   input logic obsReady, input logic [3:0] obsData,
                                   input logic [CW-1:0] obsCount);
        int age;
        age = cycle - lastStart[i];
        checkOutput($sformatf("load%0d", i), 32'(obsLoad), 32'(age < holdOf[i]));
        checkOutput($sformatf("busy%0d", i), 32'(obsBusy), 32'(age < holdOf[i] + gapOf[i]));
        checkOutput($sformatf("data%0d", i), 32'(obsData), 32'(lastData[i]));
        checkOutput($sformatf("count%0d", i), 32'(obsCount), 32'(modelQ[i].size()));
        checkOutput($sformatf("ready%0d", i), 32'(obsReady), 32'(modelQ[i].size() < DEPTH));
    endtask

    task automatic compareAll();
        compareInstance(0, load0, busy0, ready0, data0, count0);
        compareInstance(1, load1, busy1, ready1, data1, count1);
    endtask

    // Present one producer beat, advance one edge, update the model and compare
    task automatic applyStimulus(input logic valid, input logic [3:0] word);
        inValid = valid;
        inData = word;
        @(posedge clk);
        cycle++;
        modelEdge(0);
        modelEdge(1);
        #1;
        compareAll();
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, 4'($urandom));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        inValid = 1'b0;
        inData = 4'h0;
        modelReset();
        #2;
        compareAll();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Single word
        applyStimulus(1'b1, 4'hA);
        idleCycles(10);

        // Burst of four consecutive words
        for (int w = 1; w <= 4; w++) begin
            applyStimulus(1'b1, 4'(w));
        end
        idleCycles(16);

        // Sustained overflow pressure, exercising full hold-off and pointer wrap
        for (int k = 0; k < 24; k++) begin
            applyStimulus(1'b1, 4'(k + 5));
        end
        idleCycles(30);

        // Reset while the slow instance is mid-pulse with words queued
        for (int w = 0; w < 4; w++) begin
            applyStimulus(1'b1, 4'(4'hC + w));
        end
        applyStimulus(1'b0, 4'h0);
        #3;
        rst_n = 1'b0;
        inValid = 1'b0;
        #1;
        modelReset();
        compareAll();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        idleCycles(8);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            applyStimulus(1'($urandom_range(0, 99) < 55), 4'($urandom));
        end

        // Long idle: data holds the last word, no pulses
        idleCycles(30);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
